// File: rtl/vt_encoder_if.sv
// Request/response bundle for the VT encoder: start and data go in,
// codeword and status come back.
interface vt_encoder_if #(
  parameter int N = 10,
  parameter int K = 6
);
  logic         start;
  logic [K-1:0] data;
  logic [N:1]   codeword;
  logic         busy;
  logic         done;

  modport master (output start, output data, input codeword, input busy, input done);
  modport slave  (input start, input data, output codeword, output busy, output done);
endinterface

// File: rtl/vt_encoder.sv
// Systematic Varshamov-Tenengolts encoder. Data bits fill the non-power-of-two
// positions in ascending order. The weighted sum is built up one position per
// cycle, and the power-of-two positions then get the parity that makes
// sum(i*x_i) mod (n+1) equal a.
//
// state  | meaning
// IDLE   | waiting for start; holds the last codeword
// ACCUM  | walking pos 1..n, placing data bits and accumulating the sum
// PARITY | writing d = (a - sum) mod (n+1) into positions 1,2,4,...
// DONE   | one-cycle done pulse, then back to IDLE
module vt_encoder #(
  parameter int n = 10,
  parameter int a = 0
) (
  input  logic        clk,
  input  logic        rst,
  vt_encoder_if.slave bus
);
  localparam int M  = $clog2(n + 1);
  localparam int K  = n - M;
  localparam int SW = $clog2(n + 1);
  localparam int PW = $clog2(n + 1);

  // The mod arithmetic runs in SW bits. n+1 may truncate to zero when it is a
  // power of two, and that still gives the right parity value modulo 2^SW.
  localparam logic [SW:0]   MOD_EXT = (SW + 1)'(n + 1);
  localparam logic [SW-1:0] MOD_SW  = SW'(n + 1);
  localparam logic [SW-1:0] A_SW    = SW'(a);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  if (n < 3) begin : g_bad_n
    $error("vt_encoder: n must be >= 3");
  end
  if (a < 0 || a > n) begin : g_bad_a
    $error("vt_encoder: a must lie in 0..n");
  end

  logic [1:0]    state_q, state_d;
  logic [n:1]    codeword_q, codeword_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [K-1:0]  shreg_q, shreg_d;
  logic [SW:0]   sum_ext;
  logic [SW-1:0] parity_v;

  // Next-state logic: start acceptance, the serial accumulate, and the parity write.
  always_comb begin
    state_d    = state_q;
    codeword_d = codeword_q;
    sum_d      = sum_q;
    pos_d      = pos_q;
    shreg_d    = shreg_q;
    sum_ext    = '0;
    parity_v   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d    = bus.data;
          codeword_d = '0;
          sum_d      = '0;
          pos_d      = PW'(1);
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if ((pos_q & (pos_q - PW'(1))) == '0) begin
          for (int i = 1; i <= n; i++) begin
            if (pos_q == PW'(i)) codeword_d[i] = 1'b0;
          end
        end else begin
          for (int i = 1; i <= n; i++) begin
            if (pos_q == PW'(i)) codeword_d[i] = shreg_q[0];
          end
          shreg_d = shreg_q >> 1;
          if (shreg_q[0]) begin
            sum_ext = {1'b0, sum_q} + (SW + 1)'(pos_q);
            if (sum_ext >= MOD_EXT) sum_ext = sum_ext - MOD_EXT;
            sum_d = sum_ext[SW-1:0];
          end
        end
        if (pos_q == PW'(n)) state_d = S_PARITY;
        else                 pos_d   = pos_q + PW'(1);
      end
      S_PARITY: begin
        if (sum_q > A_SW) parity_v = MOD_SW - (sum_q - A_SW);
        else              parity_v = A_SW - sum_q;
        for (int i = 1; i <= n; i++) begin
          for (int j = 0; j < M; j++) begin
            if (i == (1 << j)) codeword_d[i] = parity_v[j];
          end
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any encode in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      codeword_q <= '0;
      sum_q      <= '0;
      pos_q      <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      codeword_q <= codeword_d;
      sum_q      <= sum_d;
      pos_q      <= pos_d;
      shreg_q    <= shreg_d;
    end
  end

  assign bus.codeword = codeword_q;
  assign bus.busy     = (state_q == S_ACCUM) || (state_q == S_PARITY);
  assign bus.done     = (state_q == S_DONE);
endmodule

// File: tb/tb_vt_encoder.sv
// Bench for vt_encoder: one DUT per syndrome a = 0..n, all driven by the same
// stimulus, and each checked against a spec-level arithmetic model.
module tb_vt_encoder;
  localparam int NN = 10;
  localparam int KK = 6;
  localparam int MD = NN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [KK-1:0] data = '0;

  always #5 clk = ~clk;

  logic [NN:1] cw_arr   [0:NN];
  logic        busy_arr [0:NN];
  logic        done_arr [0:NN];

  for (genvar g = 0; g <= NN; g++) begin : g_dut
    vt_encoder_if #(.N(NN), .K(KK)) u_if ();
    assign u_if.start  = start;
    assign u_if.data   = data;
    assign cw_arr[g]   = u_if.codeword;
    assign busy_arr[g] = u_if.busy;
    assign done_arr[g] = u_if.done;
    vt_encoder #(.n(NN), .a(g)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected codeword built directly from the code definition.
  function automatic logic [NN:1] model(input logic [KK-1:0] d, input int av);
    logic [NN:1] cw;
    int s, k, pd;
    cw = '0;
    s = 0;
    k = 0;
    for (int p = 1; p <= NN; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        if (d[k]) s += p;
        k++;
      end
    end
    pd = (((av - s) % MD) + MD) % MD;
    for (int j = 0; (1 << j) <= NN; j++) cw[1 << j] = pd[j];
    return cw;
  endfunction

  function automatic int checksum(input logic [NN:1] cw);
    int s;
    s = 0;
    for (int i = 1; i <= NN; i++) if (cw[i]) s += i;
    return s % MD;
  endfunction

  // Launches one encode and returns at the negedge where done is seen.
  // re_at > 0 re-pulses start with re_d during that cycle of the encode.
  task automatic run_encode(input logic [KK-1:0] d, input int re_at, input logic [KK-1:0] re_d,
                            output int lat, output int bcnt);
    int c;
    lat = -1;
    bcnt = 0;
    @(negedge clk);
    start = 1'b1;
    data = d;
    @(negedge clk);
    start = 1'b0;
    data = ~d;
    c = 1;
    while (c <= 40) begin
      if (busy_arr[0]) bcnt++;
      if (done_arr[0]) begin
        lat = c;
        break;
      end
      if (c == re_at) begin
        start = 1'b1;
        data = re_d;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [KK-1:0] data;
    int            av;
    logic [NN:1]   exp_cw;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat, bc, done_seen;
    logic [KK-1:0] d;

    vecs[0] = '{data: 6'b000000, av: 0, exp_cw: 10'b0000000000};
    vecs[1] = '{data: 6'b000001, av: 0, exp_cw: 10'b0010000100};
    vecs[2] = '{data: 6'b111111, av: 0, exp_cw: 10'b1101111100};
    vecs[3] = '{data: 6'b000000, av: 5, exp_cw: 10'b0000001001};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_codeword", 32'(cw_arr[0]), 32'd0);
    chk("reset_busy", 32'(busy_arr[0]), 32'd0);
    chk("reset_done", 32'(done_arr[0]), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run_encode(vecs[v].data, 0, '0, lat, bc);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd12);
      chk($sformatf("vec%0d_busy_cycles", v), 32'(bc), 32'd11);
      chk($sformatf("vec%0d_codeword", v), 32'(cw_arr[vecs[v].av]), 32'(vecs[v].exp_cw));
    end

    run_encode(6'b101010, 4, 6'b010101, lat, bc);
    chk("repulse_latency", 32'(lat), 32'd12);
    chk("repulse_codeword", 32'(cw_arr[0]), 32'(model(6'b101010, 0)));
    run_encode(6'b010101, 0, '0, lat, bc);
    chk("b2b_latency", 32'(lat), 32'd12);
    chk("b2b_codeword", 32'(cw_arr[0]), 32'(model(6'b010101, 0)));

    @(negedge clk);
    start = 1'b1;
    data = 6'b111111;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_codeword", 32'(cw_arr[3]), 32'd0);
    chk("abort_busy", 32'(busy_arr[3]), 32'd0);
    chk("abort_done", 32'(done_arr[3]), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_arr[0]) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    for (int it = 0; it < 1000; it++) begin
      d = KK'($urandom);
      run_encode(d, 0, '0, lat, bc);
      chk("rand_latency", 32'(lat), 32'd12);
      for (int g = 0; g <= NN; g++) begin
        chk($sformatf("rand_codeword_a%0d_d%0h", g, d), 32'(cw_arr[g]), 32'(model(d, g)));
        chk($sformatf("rand_checksum_a%0d_d%0h", g, d), 32'(checksum(cw_arr[g])), 32'(g));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
